// File: rtl/spmv_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : spmv_axi_pkg
//  Description : Shared AXI constants, log2 helper and coalescer FSM states
//                for the SpMV kernel AXI adapters.
//  Revision    : 1.0 - initial release
// ============================================================================
package spmv_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  // Normal non-cacheable, modifiable (bufferable merges allowed downstream)
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;

  // Ceiling log2; exact for the power-of-two sizes used here
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_FLUSH_AW = 3'd2,
    ST_FLUSH_W  = 3'd3,
    ST_WAIT_B   = 3'd4
  } coalesce_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_coalesce_w_if.sv
`default_nettype none
// ============================================================================
//  Interface   : axi_coalesce_w_if
//  Description : AXI write-channel bundle (AW, W, B) with master/slave views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_coalesce_w_if #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]       awid;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                awlen;
  logic [2:0]                awsize;
  logic [1:0]                awburst;
  logic                      awlock;
  logic [3:0]                awcache;
  logic [2:0]                awprot;
  logic [3:0]                awqos;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wlast;
  logic                      wvalid;
  logic                      wready;
  logic [ID_WIDTH-1:0]       bid;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/coalesce_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : coalesce_line_buf
//  Description : One-line write buffer: byte-enabled data RAM plus per-byte
//                strobe map. One write port, one async read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module coalesce_line_buf
  import spmv_axi_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int DATA_WIDTH = 32,
  localparam int BYTES     = DATA_WIDTH / 8,
  localparam int IDX_W     = clogb2(BURST_LEN)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BYTES-1:0]      wr_strb,
  input  logic                  clr,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [BYTES-1:0]      rd_strb,
  output logic                  map_full,
  output logic                  map_empty
);

  logic [DATA_WIDTH-1:0]            mem [BURST_LEN];
  logic [BURST_LEN-1:0][BYTES-1:0]  map_q;

  // Data RAM: only strobed bytes are written, contents are not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Strobe map: accumulates written bytes, cleared once the burst is acknowledged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      map_q <= '0;
    end else if (clr) begin
      map_q <= '0;
    end else if (wr_en) begin
      map_q[wr_idx] <= map_q[wr_idx] | wr_strb;
    end
  end

  assign rd_data   = mem[rd_idx];
  assign rd_strb   = map_q[rd_idx];
  assign map_full  = &map_q;
  assign map_empty = ~|map_q;

endmodule
`default_nettype wire

// File: rtl/axi_coalesce_w.sv
`default_nettype none
// ============================================================================
//  Module      : axi_coalesce_w
//  Description : Merges single-beat AXI writes into a one-line buffer and
//                emits full-line INCR bursts. Optional idle auto-flush is
//                enabled by defining COALESCE_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_coalesce_w
  import spmv_axi_pkg::*;
#(
  parameter int C_M_AXI_BURST_LEN  = 16,
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 48,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic              clk,
  input  logic              rstn,
  axi_coalesce_w_if.slave   s_axi,
  axi_coalesce_w_if.master  m_axi,
  input  logic              flush,
  output logic              idle,
  output logic              wr_err
);

  localparam int BYTES  = C_M_AXI_DATA_WIDTH / 8;
  localparam int LINE   = C_M_AXI_BURST_LEN * BYTES;
  localparam int BYTE_W = clogb2(BYTES);
  localparam int OFF_W  = clogb2(LINE);
  localparam int IDX_W  = clogb2(C_M_AXI_BURST_LEN);
  localparam logic [C_M_AXI_ADDR_WIDTH-1:0] OFF_MASK = C_M_AXI_ADDR_WIDTH'(LINE - 1);

  coalesce_state_e state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] line_base_q;
  logic                s_bvalid_q;
  logic                flush_pend_q;
  logic [IDX_W-1:0]    beat_q;
  logic                wr_err_q;
  logic                req, hit, accept, miss, trigger, last_beat, tmo_hit;
  logic                map_full, map_empty;

  assign req       = s_axi.awvalid && s_axi.wvalid;
  assign hit       = (s_axi.awaddr & ~OFF_MASK) == line_base_q;
  assign accept    = req && !s_bvalid_q &&
                     ((state_q == ST_IDLE) || ((state_q == ST_FILL) && hit));
  // A write to another line can only be taken after the current line drains
  assign miss      = (state_q == ST_FILL) && req && !hit;
  assign trigger   = miss || map_full || flush || flush_pend_q || tmo_hit;
  assign last_beat = beat_q == IDX_W'(C_M_AXI_BURST_LEN - 1);

`ifdef COALESCE_TIMEOUT_EN
  localparam int TMO_W = clogb2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;

  // Idle countdown: reloaded by every accept, runs down while the line sits in FILL
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_q <= '0;
    end else if (accept) begin
      tmo_q <= TMO_W'(TIMEOUT_CYCLES - 1);
    end else if ((state_q == ST_FILL) && (tmo_q != '0)) begin
      tmo_q <= tmo_q - TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == ST_FILL) && (tmo_q == '0);
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: an accept in FILL always wins over any flush trigger
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_FILL;
      ST_FILL:     if (!accept && trigger) state_d = ST_FLUSH_AW;
      ST_FLUSH_AW: if (m_axi.awready) state_d = ST_FLUSH_W;
      ST_FLUSH_W:  if (m_axi.wready && last_beat) state_d = ST_WAIT_B;
      ST_WAIT_B:   if (m_axi.bvalid) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Line base, slave response, latched flush request, beat counter, error flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_base_q  <= '0;
      s_bvalid_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      beat_q       <= '0;
      wr_err_q     <= 1'b0;
    end else begin
      if (accept && (state_q == ST_IDLE)) line_base_q <= s_axi.awaddr & ~OFF_MASK;
      if (accept)              s_bvalid_q <= 1'b1;
      else if (s_axi.bready)   s_bvalid_q <= 1'b0;
      // A flush that collides with an accept is held until the next FILL cycle
      flush_pend_q <= (state_q == ST_FILL) && accept && (flush || flush_pend_q);
      if (state_q == ST_FLUSH_AW)                     beat_q <= '0;
      else if ((state_q == ST_FLUSH_W) && m_axi.wready) beat_q <= beat_q + IDX_W'(1);
      if (m_axi.bvalid && (m_axi.bresp != AXI_RESP_OKAY)) wr_err_q <= 1'b1;
    end
  end

  logic [C_M_AXI_DATA_WIDTH-1:0] rd_data;
  logic [BYTES-1:0]              rd_strb;

  coalesce_line_buf #(
    .BURST_LEN  (C_M_AXI_BURST_LEN),
    .DATA_WIDTH (C_M_AXI_DATA_WIDTH)
  ) u_line_buf (
    .clk       (clk),
    .rstn      (rstn),
    .wr_en     (accept),
    .wr_idx    (s_axi.awaddr[OFF_W-1:BYTE_W]),
    .wr_data   (s_axi.wdata),
    .wr_strb   (s_axi.wstrb),
    .clr       ((state_q == ST_WAIT_B) && m_axi.bvalid),
    .rd_idx    (beat_q),
    .rd_data   (rd_data),
    .rd_strb   (rd_strb),
    .map_full  (map_full),
    .map_empty (map_empty)
  );

  // Slave side: posted writes, response is always OKAY
  assign s_axi.awready = accept;
  assign s_axi.wready  = accept;
  assign s_axi.bid     = '0;
  assign s_axi.bresp   = AXI_RESP_OKAY;
  assign s_axi.bvalid  = s_bvalid_q;

  // Master side: one fixed-length INCR burst per line
  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = line_base_q;
  assign m_axi.awlen   = 8'(C_M_AXI_BURST_LEN - 1);
  assign m_axi.awsize  = 3'(BYTE_W);
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_MODIFIABLE;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = (state_q == ST_FLUSH_AW);
  assign m_axi.wdata   = rd_data;
  assign m_axi.wstrb   = rd_strb;
  assign m_axi.wlast   = (state_q == ST_FLUSH_W) && last_beat;
  assign m_axi.wvalid  = (state_q == ST_FLUSH_W);
  assign m_axi.bready  = 1'b1;

  assign idle   = (state_q == ST_IDLE) && map_empty;
  assign wr_err = wr_err_q;

  // Slave burst attributes are ignored (single beats only); master bid is ignored
  logic unused_inputs;
  assign unused_inputs = ^{s_axi.awid, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                           s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                           s_axi.wlast, m_axi.bid};

endmodule
`default_nettype wire

// File: tb/tb_axi_coalesce_w.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_axi_coalesce_w
//  Description : Directed self-checking bench for axi_coalesce_w.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_coalesce_w;

  localparam int BL  = 16;
  localparam int IDW = 1;
  localparam int AW  = 48;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;
  logic idle, wr_err;
  int   checks = 0;
  int   errors = 0;

  axi_coalesce_w_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_if ();
  axi_coalesce_w_if #(.ID_WIDTH(IDW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  axi_coalesce_w #(
    .C_M_AXI_BURST_LEN  (BL),
    .C_M_AXI_ID_WIDTH   (IDW),
    .C_M_AXI_ADDR_WIDTH (AW),
    .C_M_AXI_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES     (64)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_axi  (s_if),
    .m_axi  (m_if),
    .flush  (flush),
    .idle   (idle),
    .wr_err (wr_err)
  );

  always #5 clk = ~clk;

  // Captured burst
  logic [AW-1:0] cap_addr;
  logic [7:0]    cap_len;
  logic [2:0]    cap_size;
  logic [1:0]    cap_burst;
  logic [3:0]    cap_cache;
  logic [31:0]   cap_data [BL];
  logic [3:0]    cap_strb [BL];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic with_flush);
    bit got;
    got = 1'b0;
    s_if.awaddr  = addr;
    s_if.wdata   = data;
    s_if.wstrb   = strb;
    s_if.awvalid = 1'b1;
    s_if.wvalid  = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (s_if.awready) begin
        got = 1'b1;
        if (with_flush) flush = 1'b1;
      end
    end
    chk("wr_accept", got, 1);
    @(posedge clk); #1;
    s_if.awvalid = 1'b0;
    s_if.wvalid  = 1'b0;
    flush        = 1'b0;
    chk("s_bvalid_after_accept", s_if.bvalid, 1);
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic run_burst(input logic [1:0] resp);
    bit seen, w_early, done;
    int nbeats, last_idx;
    seen = 1'b0; w_early = 1'b0; done = 1'b0; nbeats = 0; last_idx = -1;
    for (int i = 0; i < BL; i++) begin
      cap_data[i] = 'x;
      cap_strb[i] = 'x;
    end
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (m_if.wvalid) w_early = 1'b1;
      if (m_if.awvalid) seen = 1'b1;
    end
    chk("m_awvalid_seen", seen, 1);
    if (!seen) return;
    cap_addr  = m_if.awaddr;
    cap_len   = m_if.awlen;
    cap_size  = m_if.awsize;
    cap_burst = m_if.awburst;
    cap_cache = m_if.awcache;
    m_if.awready = 1'b1;
    @(posedge clk); #1;
    m_if.awready = 1'b0;
    chk("w_before_aw", w_early, 0);
    m_if.wready = 1'b1;
    for (int i = 0; i < 300 && !done && nbeats < 40; i++) begin
      @(negedge clk);
      if (m_if.wvalid) begin
        if (nbeats < BL) begin
          cap_data[nbeats] = m_if.wdata;
          cap_strb[nbeats] = m_if.wstrb;
        end
        if (m_if.wlast) begin
          last_idx = nbeats;
          done = 1'b1;
        end
        nbeats++;
      end
    end
    @(posedge clk); #1;
    m_if.wready = 1'b0;
    chk("w_beats", nbeats, BL);
    chk("wlast_idx", last_idx, BL - 1);
    m_if.bresp  = resp;
    m_if.bvalid = 1'b1;
    @(posedge clk); #1;
    m_if.bvalid = 1'b0;
    m_if.bresp  = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    s_if.awid = '0; s_if.awaddr = '0; s_if.awlen = 8'd0; s_if.awsize = 3'd2;
    s_if.awburst = 2'b01; s_if.awlock = 1'b0; s_if.awcache = 4'd0; s_if.awprot = 3'd0;
    s_if.awqos = 4'd0; s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0;
    s_if.wlast = 1'b1; s_if.wvalid = 1'b0; s_if.bready = 1'b1;
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bid = '0; m_if.bresp = 2'b00;
    m_if.bvalid = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_m_awvalid", m_if.awvalid, 0);
    chk("rst_m_wvalid", m_if.wvalid, 0);
    chk("rst_s_bvalid", s_if.bvalid, 0);
    chk("rst_wr_err", wr_err, 0);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;

    // Four writes, explicit flush
    for (int i = 0; i < 4; i++) do_write(AW'(i * 4), 32'h1111_0000 + 32'(i), 4'hF, 1'b0);
    chk("t1_not_idle", idle, 0);
    flush_pulse();
    run_burst(2'b00);
    chk("t1_awaddr", cap_addr, 48'h0);
    chk("t1_awlen", cap_len, 8'd15);
    chk("t1_awsize", cap_size, 3'd2);
    chk("t1_awburst", cap_burst, 2'b01);
    chk("t1_awcache", cap_cache, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      chk("t1_strb_hit", cap_strb[i], 4'hF);
      chk("t1_data_hit", cap_data[i], 32'h1111_0000 + 32'(i));
    end
    for (int i = 4; i < BL; i++) chk("t1_strb_untouched", cap_strb[i], 4'h0);
    chk("t1_idle_after_b", idle, 1);

    // Flush request while idle is ignored
    flush_pulse();
    repeat (5) @(negedge clk);
    chk("idle_flush_no_aw", m_if.awvalid, 0);
    chk("idle_flush_still_idle", idle, 1);

    // Full line triggers auto-flush
    for (int i = 0; i < BL; i++) do_write(AW'(48'h40 + i * 4), 32'hD000_0000 | 32'(i), 4'hF, 1'b0);
    run_burst(2'b00);
    chk("t2_awaddr", cap_addr, 48'h40);
    chk("t2_beat0", cap_data[0], 32'hD000_0000);
    chk("t2_beat15", cap_data[15], 32'hD000_000F);
    chk("t2_strb15", cap_strb[15], 4'hF);
    chk("t2_idle_after_b", idle, 1);

    // Miss flushes the open line, then the missing write is taken
    do_write(48'h10, 32'hCAFE_0010, 4'hF, 1'b0);
    fork
      do_write(48'h100, 32'h1234_5678, 4'hF, 1'b0);
      run_burst(2'b00);
    join
    chk("t3_first_awaddr", cap_addr, 48'h0);
    chk("t3_beat4_data", cap_data[4], 32'hCAFE_0010);
    chk("t3_beat4_strb", cap_strb[4], 4'hF);
    chk("t3_beat0_strb", cap_strb[0], 4'h0);
    flush_pulse();
    run_burst(2'b00);
    chk("t3_second_awaddr", cap_addr, 48'h100);
    chk("t3_second_beat0", cap_data[0], 32'h1234_5678);

    // Byte merge within one beat
    do_write(48'h8, 32'h0000_AAAA, 4'h3, 1'b0);
    do_write(48'h8, 32'hBBBB_0000, 4'hC, 1'b0);
    flush_pulse();
    run_burst(2'b00);
    chk("t4_merge_data", cap_data[2], 32'hBBBB_AAAA);
    chk("t4_merge_strb", cap_strb[2], 4'hF);
    chk("t4_beat1_strb", cap_strb[1], 4'h0);

    // Flush pulse coinciding with an accept is not lost
    do_write(48'h400, 32'h0000_0400, 4'hF, 1'b0);
    do_write(48'h404, 32'h0000_0404, 4'hF, 1'b1);
    run_burst(2'b00);
    chk("t5_awaddr", cap_addr, 48'h400);
    chk("t5_beat1_strb", cap_strb[1], 4'hF);
    chk("t5_beat1_data", cap_data[1], 32'h0000_0404);

    // Idle timeout (or its absence)
`ifdef COALESCE_TIMEOUT_EN
    do_write(48'h200, 32'h0000_0200, 4'hF, 1'b0);
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (m_if.awvalid) seen = 1'b1;
    end
    // 64 idle cycles, then one cycle to raise AW (+/-1 for sampling phase)
    chk("tmo_latency_in_window", (n >= 64 && n <= 67), 1);
    chk("tmo_not_early", (n >= 64), 1);
    run_burst(2'b00);
`else
    do_write(48'h200, 32'h0000_0200, 4'hF, 1'b0);
    repeat (100) @(negedge clk);
    chk("no_timeout_no_aw", m_if.awvalid, 0);
    flush_pulse();
    run_burst(2'b00);
`endif
    chk("tmo_awaddr", cap_addr, 48'h200);

    // Error response makes wr_err sticky
    do_write(48'h500, 32'h0000_0500, 4'hF, 1'b0);
    flush_pulse();
    run_burst(2'b10);
    chk("err_set", wr_err, 1);
    do_write(48'h600, 32'h0000_0600, 4'hF, 1'b0);
    flush_pulse();
    run_burst(2'b00);
    chk("err_sticky", wr_err, 1);

    // Reset in the middle of the W phase
    do_write(48'h300, 32'h0000_0300, 4'hF, 1'b0);
    flush_pulse();
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (m_if.awvalid) seen = 1'b1;
    end
    chk("midw_aw_seen", seen, 1);
    m_if.awready = 1'b1;
    @(posedge clk); #1;
    m_if.awready = 1'b0;
    m_if.wready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midw_wvalid_active", m_if.wvalid, 1);
    rstn = 1'b0;
    #1;
    chk("midw_rst_awvalid", m_if.awvalid, 0);
    chk("midw_rst_wvalid", m_if.wvalid, 0);
    chk("midw_rst_s_bvalid", s_if.bvalid, 0);
    chk("midw_rst_idle", idle, 1);
    chk("midw_rst_wr_err", wr_err, 0);
    m_if.wready = 1'b0;
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
